// File: rtl/accumulator_optype.sv
// Command encoding understood by the Accumulator block.
package accumulator_optype;
  typedef enum logic [1:0] {
    WRITE = 2'd0,
    INC   = 2'd1,
    DEC   = 2'd2
  } acu_op_t;
endpackage

// File: rtl/acc_op_sequencer.sv
// Sequences 4004 accumulator-group and register-arithmetic instructions into Accumulator commands.
// Optional DAA/KBP support is enabled by defining ACC_SEQ_DAA_KBP_EN.
//
// state    | meaning
// IDLE     | ready for the next instruction byte
// REG_WAIT | reading register operand R from the index register file
// ISSUE    | one-cycle command to the Accumulator, shadow/link update
module acc_op_sequencer (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [7:0]                  instr,
  input  logic                        instr_valid,
  output logic                        instr_ready,
  output logic                        reg_req,
  output logic [3:0]                  reg_addr,
  input  logic                        reg_ack,
  input  logic [3:0]                  reg_rdata,
  output logic                        acc_select,
  output accumulator_optype::acu_op_t acc_opcode,
  output logic [3:0]                  acc_data,
  output logic [3:0]                  acc_value,
  output logic                        link,
  output logic                        illegal_op
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REG_WAIT = 2'd1,
    ISSUE    = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] instr_q, instr_d;
  logic [3:0] rdata_q, rdata_d;
  logic [3:0] acc_q, acc_d;
  logic       link_q, link_d;
  logic [4:0] sum5;
  logic       wr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      rdata_q <= '0;
      acc_q   <= '0;
      link_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      rdata_q <= rdata_d;
      acc_q   <= acc_d;
      link_q  <= link_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          if (instr[7:4] == 4'h8 || instr[7:4] == 4'h9 || instr[7:4] == 4'hA)
            state_d = REG_WAIT;
          else
            state_d = ISSUE;
        end
      end
      REG_WAIT: begin
        if (reg_ack) begin
          rdata_d = reg_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign instr_ready = (state_q == IDLE);
  assign reg_req     = (state_q == REG_WAIT);
  assign reg_addr    = reg_req ? instr_q[3:0] : 4'd0;
  assign acc_value   = acc_q;
  assign link        = link_q;

  // WRITE-class instructions compute acc_d/link_d and raise wr; the command data is the new shadow.
  always_comb begin
    acc_d      = acc_q;
    link_d     = link_q;
    sum5       = '0;
    wr         = 1'b0;
    acc_select = 1'b0;
    acc_opcode = accumulator_optype::WRITE;
    acc_data   = 4'd0;
    illegal_op = 1'b0;
    if (state_q == ISSUE) begin
      case (instr_q[7:4])
        4'h8: begin
          sum5   = {1'b0, acc_q} + {1'b0, rdata_q} + {4'd0, link_q};
          acc_d  = sum5[3:0];
          link_d = sum5[4];
          wr     = 1'b1;
        end
        4'h9: begin
          sum5   = {1'b0, acc_q} + {1'b0, ~rdata_q} + {4'd0, ~link_q};
          acc_d  = sum5[3:0];
          link_d = sum5[4];
          wr     = 1'b1;
        end
        4'hA: begin
          acc_d = rdata_q;
          wr    = 1'b1;
        end
        4'hF: begin
          case (instr_q[3:0])
            4'h0: begin
              acc_d  = 4'd0;
              link_d = 1'b0;
              wr     = 1'b1;
            end
            4'h1: link_d = 1'b0;
            4'h2: begin
              acc_select = 1'b1;
              acc_opcode = accumulator_optype::INC;
              acc_d      = acc_q + 4'd1;
              link_d     = (acc_q == 4'd15);
            end
            4'h3: link_d = ~link_q;
            4'h4: begin
              acc_d = ~acc_q;
              wr    = 1'b1;
            end
            4'h5: begin
              acc_d  = {acc_q[2:0], link_q};
              link_d = acc_q[3];
              wr     = 1'b1;
            end
            4'h6: begin
              acc_d  = {link_q, acc_q[3:1]};
              link_d = acc_q[0];
              wr     = 1'b1;
            end
            4'h7: begin
              acc_d  = {3'b000, link_q};
              link_d = 1'b0;
              wr     = 1'b1;
            end
            4'h8: begin
              acc_select = 1'b1;
              acc_opcode = accumulator_optype::DEC;
              acc_d      = acc_q - 4'd1;
              link_d     = (acc_q != 4'd0);
            end
            4'h9: begin
              acc_d  = link_q ? 4'd10 : 4'd9;
              link_d = 1'b0;
              wr     = 1'b1;
            end
            4'hA: link_d = 1'b1;
`ifdef ACC_SEQ_DAA_KBP_EN
            4'hB: begin
              if (acc_q > 4'd9 || link_q) begin
                sum5  = {1'b0, acc_q} + 5'd6;
                acc_d = sum5[3:0];
                if (sum5[4])
                  link_d = 1'b1;
              end
              wr = 1'b1;
            end
            4'hC: begin
              case (acc_q)
                4'd0:    acc_d = 4'd0;
                4'd1:    acc_d = 4'd1;
                4'd2:    acc_d = 4'd2;
                4'd4:    acc_d = 4'd3;
                4'd8:    acc_d = 4'd4;
                default: acc_d = 4'd15;
              endcase
              wr = 1'b1;
            end
`endif
            default: illegal_op = 1'b1;
          endcase
        end
        default: illegal_op = 1'b1;
      endcase
      if (wr) begin
        acc_select = 1'b1;
        acc_opcode = accumulator_optype::WRITE;
        acc_data   = acc_d;
      end
    end
  end

endmodule

// File: tb/tb_acc_op_sequencer.sv
// Directed self-checking bench for acc_op_sequencer; honours ACC_SEQ_DAA_KBP_EN when defined.
module tb_acc_op_sequencer;
  import accumulator_optype::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] instr = 8'h00;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic       reg_req;
  logic [3:0] reg_addr;
  logic       reg_ack = 1'b0;
  logic [3:0] reg_rdata = 4'd0;
  logic       acc_select;
  acu_op_t    acc_opcode;
  logic [3:0] acc_data;
  logic [3:0] acc_value;
  logic       link;
  logic       illegal_op;

  int total = 0;
  int bad = 0;

  acc_op_sequencer dut (
    .clock(clock), .reset(reset),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .reg_req(reg_req), .reg_addr(reg_addr), .reg_ack(reg_ack), .reg_rdata(reg_rdata),
    .acc_select(acc_select), .acc_opcode(acc_opcode), .acc_data(acc_data),
    .acc_value(acc_value), .link(link), .illegal_op(illegal_op)
  );

  always #5 clock = ~clock;

  task automatic chk1(input string tag, input logic o, input logic e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, o, e);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] o, input logic [3:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic chkop(input string tag, input acu_op_t o, input acu_op_t e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic start(input logic [7:0] b);
    instr = b;
    instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
  endtask

  // Accumulator-only instruction: accepted, one ISSUE cycle, then back to IDLE.
  task automatic acc_op(input string tag, input logic [7:0] b, input logic esel,
                        input acu_op_t eop, input logic [3:0] edata, input logic eill,
                        input logic [3:0] ea, input logic el);
    chk1({tag, ".ready"}, instr_ready, 1'b1);
    start(b);
    chk1({tag, ".busy"}, instr_ready, 1'b0);
    chk1({tag, ".sel"}, acc_select, esel);
    chk1({tag, ".ill"}, illegal_op, eill);
    if (esel) begin
      chkop({tag, ".op"}, acc_opcode, eop);
      if (eop == WRITE)
        chk4({tag, ".data"}, acc_data, edata);
    end
    cyc();
    chk4({tag, ".A"}, acc_value, ea);
    chk1({tag, ".L"}, link, el);
    chk1({tag, ".sel_after"}, acc_select, 1'b0);
  endtask

  // Register instruction with wait_n cycles of ack latency; valid is waved during the wait.
  task automatic reg_op(input string tag, input logic [7:0] b, input int wait_n,
                        input logic [3:0] rd, input logic [3:0] edata,
                        input logic [3:0] ea, input logic el);
    chk1({tag, ".ready"}, instr_ready, 1'b1);
    start(b);
    for (int i = 0; i < wait_n; i++) begin
      chk1({tag, ".wreq"}, reg_req, 1'b1);
      chk1({tag, ".wbusy"}, instr_ready, 1'b0);
      chk1({tag, ".wsel"}, acc_select, 1'b0);
      instr = 8'hF2;
      instr_valid = 1'b1;
      cyc();
    end
    instr_valid = 1'b0;
    chk1({tag, ".req"}, reg_req, 1'b1);
    chk4({tag, ".addr"}, reg_addr, b[3:0]);
    reg_ack = 1'b1;
    reg_rdata = rd;
    cyc();
    reg_ack = 1'b0;
    reg_rdata = 4'd0;
    chk1({tag, ".req_off"}, reg_req, 1'b0);
    chk1({tag, ".sel"}, acc_select, 1'b1);
    chkop({tag, ".op"}, acc_opcode, WRITE);
    chk4({tag, ".data"}, acc_data, edata);
    cyc();
    chk4({tag, ".A"}, acc_value, ea);
    chk1({tag, ".L"}, link, el);
  endtask

  initial begin
    logic       lk;
    logic [3:0] ea;

    cyc();
    cyc();
    chk1("rst.ready", instr_ready, 1'b1);
    chk1("rst.req", reg_req, 1'b0);
    chk4("rst.addr", reg_addr, 4'd0);
    chk1("rst.sel", acc_select, 1'b0);
    chkop("rst.op", acc_opcode, WRITE);
    chk4("rst.data", acc_data, 4'd0);
    chk4("rst.A", acc_value, 4'd0);
    chk1("rst.L", link, 1'b0);
    chk1("rst.ill", illegal_op, 1'b0);
    reset = 1'b0;
    cyc();

    for (int i = 0; i < 16; i++)
      acc_op("iac", 8'hF2, 1'b1, INC, 4'd0, 1'b0, 4'(i + 1), (i == 15));

    reg_op("ld3", 8'hA3, 0, 4'd7, 4'd7, 4'd7, 1'b1);
    reg_op("add5", 8'h85, 2, 4'd9, 4'd1, 4'd1, 1'b1);
    acc_op("clc", 8'hF1, 1'b0, WRITE, 4'd0, 1'b0, 4'd1, 1'b0);
    reg_op("sub_l0", 8'h92, 0, 4'd3, 4'd14, 4'd14, 1'b0);
    reg_op("ld1", 8'hA1, 0, 4'd1, 4'd1, 4'd1, 1'b0);
    acc_op("stc", 8'hFA, 1'b0, WRITE, 4'd0, 1'b0, 4'd1, 1'b1);
    reg_op("sub_l1", 8'h92, 1, 4'd3, 4'd13, 4'd13, 1'b0);

    reg_op("ld9", 8'hA0, 0, 4'd9, 4'd9, 4'd9, 1'b0);
    acc_op("ral", 8'hF5, 1'b1, WRITE, 4'd2, 1'b0, 4'd2, 1'b1);
    acc_op("rar", 8'hF6, 1'b1, WRITE, 4'd9, 1'b0, 4'd9, 1'b0);
    acc_op("cma", 8'hF4, 1'b1, WRITE, 4'd6, 1'b0, 4'd6, 1'b0);
    acc_op("cmc", 8'hF3, 1'b0, WRITE, 4'd0, 1'b0, 4'd6, 1'b1);
    acc_op("tcc", 8'hF7, 1'b1, WRITE, 4'd1, 1'b0, 4'd1, 1'b0);
    acc_op("tcs0", 8'hF9, 1'b1, WRITE, 4'd9, 1'b0, 4'd9, 1'b0);
    acc_op("stc2", 8'hFA, 1'b0, WRITE, 4'd0, 1'b0, 4'd9, 1'b1);
    acc_op("tcs1", 8'hF9, 1'b1, WRITE, 4'd10, 1'b0, 4'd10, 1'b0);
    acc_op("stc3", 8'hFA, 1'b0, WRITE, 4'd0, 1'b0, 4'd10, 1'b1);
    acc_op("clb", 8'hF0, 1'b1, WRITE, 4'd0, 1'b0, 4'd0, 1'b0);
    acc_op("dac0", 8'hF8, 1'b1, DEC, 4'd0, 1'b0, 4'd15, 1'b0);
    acc_op("dac1", 8'hF8, 1'b1, DEC, 4'd0, 1'b0, 4'd14, 1'b1);
    acc_op("ill00", 8'h00, 1'b0, WRITE, 4'd0, 1'b1, 4'd14, 1'b1);
    acc_op("illFE", 8'hFE, 1'b0, WRITE, 4'd0, 1'b1, 4'd14, 1'b1);

    reg_op("ld11", 8'hA4, 0, 4'd11, 4'd11, 4'd11, 1'b1);
    acc_op("clc2", 8'hF1, 1'b0, WRITE, 4'd0, 1'b0, 4'd11, 1'b0);
`ifdef ACC_SEQ_DAA_KBP_EN
    acc_op("daa", 8'hFB, 1'b1, WRITE, 4'd1, 1'b0, 4'd1, 1'b1);
    lk = 1'b1;
    reg_op("ld4", 8'hA6, 0, 4'd4, 4'd4, 4'd4, lk);
    acc_op("kbp", 8'hFC, 1'b1, WRITE, 4'd3, 1'b0, 4'd3, lk);
    ea = 4'd3;
`else
    acc_op("daa_ill", 8'hFB, 1'b0, WRITE, 4'd0, 1'b1, 4'd11, 1'b0);
    lk = 1'b0;
    reg_op("ld4", 8'hA6, 0, 4'd4, 4'd4, 4'd4, lk);
    acc_op("kbp_ill", 8'hFC, 1'b0, WRITE, 4'd0, 1'b1, 4'd4, lk);
    ea = 4'd4;
`endif

    reg_ack = 1'b1;
    reg_rdata = 4'hF;
    cyc();
    reg_ack = 1'b0;
    reg_rdata = 4'd0;
    chk1("stray_ack.req", reg_req, 1'b0);
    chk1("stray_ack.ready", instr_ready, 1'b1);
    chk4("stray_ack.A", acc_value, ea);

    acc_op("stc4", 8'hFA, 1'b0, WRITE, 4'd0, 1'b0, ea, 1'b1);
    start(8'hA5);
    chk1("midrst.req_before", reg_req, 1'b1);
    reset = 1'b1;
    cyc();
    chk1("midrst.req", reg_req, 1'b0);
    chk1("midrst.ready", instr_ready, 1'b1);
    chk4("midrst.A", acc_value, 4'd0);
    chk1("midrst.L", link, 1'b0);
    chk1("midrst.sel", acc_select, 1'b0);
    reset = 1'b0;
    cyc();
    chk1("post_rst.sel", acc_select, 1'b0);
    chk1("post_rst.ready", instr_ready, 1'b1);
    chk4("post_rst.A", acc_value, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
